// File: rtl/eth_dispatch.sv
// rtl/eth_dispatch.sv - holds the Ethernet header word until the classifier answers, then forwards, redirects to CPU, or drops
//
// Optional build macro: ETH_DISPATCH_STATS_EN (adds per-decision packet counters)
//
// Ports:
//   axi_aclk, axi_resetn            clock, asynchronous active-low reset
//   s_axis_t{data,keep,user,last}   input stream payload; s_axis_tvalid / s_axis_tready handshake
//   m_axis_t{data,keep,user,last}   output stream payload toward IPv4 lookup; m_axis_tvalid / m_axis_tready
//   o_pkt_word1                     first-word strobe to the header classifier
//   i_is_for_us, i_is_bmcast,       registered classifier result, sampled only while waiting
//   i_is_arp, i_is_ipv4, i_is_valid   for the decision on the held header
//   i_cnt_clr, o_cnt_fwd,           (stats build only) synchronous counter clear and
//   o_cnt_cpu, o_cnt_drop             saturating forward / CPU-redirect / drop packet counts

module eth_dispatch #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int CLS_TIMEOUT          = 4
) (
    input  logic                                axi_aclk,
    input  logic                                axi_resetn,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic                                o_pkt_word1,
    input  logic                                i_is_for_us,
    input  logic                                i_is_bmcast,
    input  logic                                i_is_arp,
    input  logic                                i_is_ipv4,
    input  logic                                i_is_valid
`ifdef ETH_DISPATCH_STATS_EN
    ,
    input  logic                                i_cnt_clr,
    output logic [31:0]                         o_cnt_fwd,
    output logic [31:0]                         o_cnt_cpu,
    output logic [31:0]                         o_cnt_drop
`endif
);

    localparam int KW = C_S_AXIS_TDATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_BODY = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    localparam logic [1:0] DEC_NONE = 2'd0;
    localparam logic [1:0] DEC_FWD  = 2'd1;
    localparam logic [1:0] DEC_CPU  = 2'd2;
    localparam logic [1:0] DEC_DROP = 2'd3;

    localparam logic [3:0] CLS_TO = 4'(CLS_TIMEOUT);

    logic [2:0]                        state_q, state_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   hdr_data_q, hdr_data_d;
    logic [KW-1:0]                     hdr_keep_q, hdr_keep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   hdr_user_q, hdr_user_d;
    logic                              hdr_last_q, hdr_last_d;
    logic [3:0]                        cnt_q, cnt_d;

    logic [7:0] sport;
    logic       sport_onehot;
    logic       from_cpu;
    logic [7:0] cpu_dst;
    logic [3:0] cnt_inc;
    logic [1:0] dec;
    logic       dst_wr;
    logic [7:0] dst_val;
    logic       s_ready;

    assign sport        = hdr_user_q[SRC_PORT_POS +: 8];
    assign sport_onehot = (sport != 8'h00) && ((sport & (sport - 8'h01)) == 8'h00);
    // Odd bit positions are CPU ports; each MAC port's CPU partner sits one bit above it.
    assign from_cpu     = |(sport & 8'hAA);
    assign cpu_dst      = (sport & 8'h55) << 1;
    assign cnt_inc      = cnt_q + 4'd1;

    // Decision for the held header; only meaningful in S_WAIT.
    always_comb begin
        dec     = DEC_NONE;
        dst_wr  = 1'b0;
        dst_val = 8'h00;
        if (state_q == S_WAIT) begin
            if (!sport_onehot) begin
                dec = DEC_DROP;
            end else if (from_cpu) begin
                // CPU-originated traffic goes straight to lookup untouched.
                dec = DEC_FWD;
            end else if (i_is_valid) begin
                if (!i_is_for_us) begin
                    dec = DEC_DROP;
                end else if (i_is_bmcast || i_is_arp || !i_is_ipv4) begin
                    dec     = DEC_CPU;
                    dst_wr  = 1'b1;
                    dst_val = cpu_dst;
                end else begin
                    // IPv4 unicast for us: lookup stage chooses the egress port.
                    dec     = DEC_FWD;
                    dst_wr  = 1'b1;
                    dst_val = 8'h00;
                end
            end else if (cnt_inc == CLS_TO) begin
                dec = DEC_DROP;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_data_d    = hdr_data_q;
        hdr_keep_d    = hdr_keep_q;
        hdr_user_d    = hdr_user_q;
        hdr_last_d    = hdr_last_q;
        cnt_d         = cnt_q;
        s_ready       = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            S_IDLE: begin
                s_ready = 1'b1;
                if (s_axis_tvalid) begin
                    hdr_data_d = s_axis_tdata;
                    hdr_keep_d = s_axis_tkeep;
                    hdr_user_d = s_axis_tuser;
                    hdr_last_d = s_axis_tlast;
                    cnt_d      = 4'd0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (dec == DEC_DROP) begin
                    state_d = S_DROP;
                end else if (dec != DEC_NONE) begin
                    state_d = S_PASS;
                    if (dst_wr) begin
                        hdr_user_d[DST_PORT_POS +: 8] = dst_val;
                    end
                end
            end
            S_PASS: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_data_q;
                m_axis_tkeep  = hdr_keep_q;
                m_axis_tuser  = hdr_user_q;
                m_axis_tlast  = hdr_last_q;
                if (m_axis_tready) begin
                    state_d = hdr_last_q ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                s_ready       = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tuser  = s_axis_tuser;
                m_axis_tlast  = s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (hdr_last_q) begin
                    state_d = S_IDLE;
                end else begin
                    s_ready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gate ready with reset so nothing is accepted while the block is held in reset.
    assign s_axis_tready = s_ready & axi_resetn;
    assign o_pkt_word1   = (state_q == S_IDLE) & s_axis_tvalid & s_axis_tready;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q    <= S_IDLE;
            hdr_data_q <= '0;
            hdr_keep_q <= '0;
            hdr_user_q <= '0;
            hdr_last_q <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            hdr_data_q <= hdr_data_d;
            hdr_keep_q <= hdr_keep_d;
            hdr_user_q <= hdr_user_d;
            hdr_last_q <= hdr_last_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef ETH_DISPATCH_STATS_EN
    logic [31:0] cnt_fwd_q, cnt_fwd_d;
    logic [31:0] cnt_cpu_q, cnt_cpu_d;
    logic [31:0] cnt_drop_q, cnt_drop_d;

    always_comb begin
        cnt_fwd_d  = cnt_fwd_q;
        cnt_cpu_d  = cnt_cpu_q;
        cnt_drop_d = cnt_drop_q;
        if (i_cnt_clr) begin
            cnt_fwd_d  = 32'd0;
            cnt_cpu_d  = 32'd0;
            cnt_drop_d = 32'd0;
        end else begin
            if (dec == DEC_FWD && cnt_fwd_q != 32'hFFFF_FFFF) begin
                cnt_fwd_d = cnt_fwd_q + 32'd1;
            end
            if (dec == DEC_CPU && cnt_cpu_q != 32'hFFFF_FFFF) begin
                cnt_cpu_d = cnt_cpu_q + 32'd1;
            end
            if (dec == DEC_DROP && cnt_drop_q != 32'hFFFF_FFFF) begin
                cnt_drop_d = cnt_drop_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            cnt_fwd_q  <= 32'd0;
            cnt_cpu_q  <= 32'd0;
            cnt_drop_q <= 32'd0;
        end else begin
            cnt_fwd_q  <= cnt_fwd_d;
            cnt_cpu_q  <= cnt_cpu_d;
            cnt_drop_q <= cnt_drop_d;
        end
    end

    assign o_cnt_fwd  = cnt_fwd_q;
    assign o_cnt_cpu  = cnt_cpu_q;
    assign o_cnt_drop = cnt_drop_q;
`endif

endmodule

// File: tb/tb_eth_dispatch.sv
// tb/tb_eth_dispatch.sv - directed self-checking bench for eth_dispatch

module tb_eth_dispatch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [127:0] s_tuser;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         pkt_word1;
    logic         for_us, bmcast, arp, ipv4, cls_valid;
`ifdef ETH_DISPATCH_STATS_EN
    logic         cnt_clr;
    logic [31:0]  cnt_fwd, cnt_cpu, cnt_drop;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [255:0] od[$];
    logic [127:0] ou[$];
    logic         ol[$];
    int           ocyc[$];
    int           w1_cnt = 0;
    int           w1_cyc = 0;
    int           in_cnt = 0;
    logic         hold_pend = 1'b0;
    logic [255:0] hold_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_dispatch dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .o_pkt_word1   (pkt_word1),
        .i_is_for_us   (for_us),
        .i_is_bmcast   (bmcast),
        .i_is_arp      (arp),
        .i_is_ipv4     (ipv4),
        .i_is_valid    (cls_valid)
`ifdef ETH_DISPATCH_STATS_EN
        ,
        .i_cnt_clr     (cnt_clr),
        .o_cnt_fwd     (cnt_fwd),
        .o_cnt_cpu     (cnt_cpu),
        .o_cnt_drop    (cnt_drop)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] wd(input logic [7:0] tag, input int i);
        return {240'h0, tag, i[7:0]};
    endfunction

    function automatic logic [127:0] mk_user(input logic [7:0] dst, input logic [7:0] src);
        return {96'h0, dst, src, 16'h5A5A};
    endfunction

    // Output / input observer, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                check("stall_valid_held", m_tvalid, 1'b1);
                check("stall_data_held", m_tdata, hold_data);
            end
            hold_pend = m_tvalid && !m_tready;
            hold_data = m_tdata;
            if (m_tvalid && m_tready) begin
                od.push_back(m_tdata);
                ou.push_back(m_tuser);
                ol.push_back(m_tlast);
                ocyc.push_back(cyc);
            end
            if (pkt_word1) begin
                w1_cnt++;
                w1_cyc = cyc;
            end
            if (s_tvalid && s_tready) in_cnt++;
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic clear_out();
        od.delete();
        ou.delete();
        ol.delete();
        ocyc.delete();
    endtask

    task automatic set_cls(input logic v, input logic fu, input logic bm, input logic ar, input logic ip);
        cls_valid = v;
        for_us    = fu;
        bmcast    = bm;
        arp       = ar;
        ipv4      = ip;
    endtask

    // Drives n_send words of an n_total-word packet; entered and left just after a rising edge.
    task automatic send_pkt(input int n_total, input int n_send, input logic [7:0] tag, input logic [127:0] user);
        for (int i = 0; i < n_send; i++) begin
            int  budget;
            bit  done;
            budget   = 0;
            done     = 1'b0;
            s_tvalid = 1'b1;
            s_tdata  = wd(tag, i);
            s_tkeep  = '1;
            s_tuser  = user;
            s_tlast  = (i == n_total - 1);
            while (!done) begin
                @(negedge clk);
                if (s_tready) done = 1'b1;
                @(posedge clk);
                #1;
                budget++;
                if (!done && budget > 300) begin
                    failures++;
                    $error("FAIL send_timeout tag=%0h word=%0d", tag, i);
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w1_base, in_base, n;
        rst_n    = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        set_cls(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ETH_DISPATCH_STATS_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_word1", pkt_word1, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 256'h0);
        check("rst_m_tuser", m_tuser, 256'h0);
        s_tvalid = 1'b0;
        #2;
        rst_n = 1'b1;
        idle_cycles(2);
        check("idle_s_tready", s_tready, 1'b1);

        // IPv4 unicast from port 0: destination forced to 00, latency 2.
        clear_out();
        w1_base = w1_cnt;
        set_cls(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_pkt(3, 3, 8'hA1, mk_user(8'hAB, 8'h01));
        idle_cycles(4);
        check("ipv4_count", od.size(), 3);
        check("ipv4_hdr_data", od[0], wd(8'hA1, 0));
        check("ipv4_hdr_user", ou[0], mk_user(8'h00, 8'h01));
        check("ipv4_w1_data", od[1], wd(8'hA1, 1));
        check("ipv4_w1_user", ou[1], mk_user(8'hAB, 8'h01));
        check("ipv4_w2_data", od[2], wd(8'hA1, 2));
        check("ipv4_last0", ol[0], 1'b0);
        check("ipv4_last2", ol[2], 1'b1);
        check("ipv4_word1_pulses", w1_cnt - w1_base, 1);
        check("ipv4_latency", ocyc[0] - w1_cyc, 2);

        // Broadcast ARP from port 2: redirected to paired CPU port 8'h20.
        clear_out();
        set_cls(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_pkt(2, 2, 8'hB2, mk_user(8'h00, 8'h10));
        idle_cycles(4);
        check("arp_count", od.size(), 2);
        check("arp_hdr_user", ou[0], mk_user(8'h20, 8'h10));
        check("arp_hdr_data", od[0], wd(8'hB2, 0));
        check("arp_w1_data", od[1], wd(8'hB2, 1));
        check("arp_last1", ol[1], 1'b1);

        // Foreign unicast from port 1: dropped, all four words consumed.
        clear_out();
        in_base = in_cnt;
        set_cls(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_pkt(4, 4, 8'hC3, mk_user(8'h00, 8'h04));
        idle_cycles(4);
        check("drop_no_output", od.size(), 0);
        check("drop_consumed", in_cnt - in_base, 4);

        // Classifier never answers: 4 waiting cycles plus 1 drop cycle with ready low.
`ifdef ETH_DISPATCH_STATS_EN
        cnt_clr = 1'b1;
        idle_cycles(1);
        cnt_clr = 1'b0;
`endif
        clear_out();
        set_cls(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(1, 1, 8'hD4, mk_user(8'h00, 8'h01));
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (s_tready) break;
            n++;
        end
        @(posedge clk);
        #1;
        check("timeout_ready_low_cycles", n, 5);
        check("timeout_no_output", od.size(), 0);
`ifdef ETH_DISPATCH_STATS_EN
        check("stats_drop", cnt_drop, 32'd1);
        check("stats_fwd", cnt_fwd, 32'd0);
`endif

        // CPU-port source, single word: passes unchanged without the classifier.
        clear_out();
        send_pkt(1, 1, 8'hE5, mk_user(8'h77, 8'h02));
        idle_cycles(4);
        check("cpu_count", od.size(), 1);
        check("cpu_user", ou[0], mk_user(8'h77, 8'h02));
        check("cpu_data", od[0], wd(8'hE5, 0));
        check("cpu_last", ol[0], 1'b1);
        check("cpu_latency", ocyc[0] - w1_cyc, 2);

        // 5-word forward under random output stalls.
        clear_out();
        set_cls(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        fork
            send_pkt(5, 5, 8'hF6, mk_user(8'h33, 8'h40));
            begin
                m_tready = 1'b0;
                idle_cycles(4);
                repeat (60) begin
                    m_tready = 1'($urandom_range(0, 1));
                    idle_cycles(1);
                end
                m_tready = 1'b1;
            end
        join
        n = 0;
        while (od.size() < 5 && n < 100) begin
            idle_cycles(1);
            n++;
        end
        idle_cycles(3);
        check("stall_count", od.size(), 5);
        check("stall_hdr_user", ou[0], mk_user(8'h00, 8'h40));
        for (int i = 0; i < 5; i++) begin
            check("stall_data", od[i], wd(8'hF6, i));
            check("stall_last", ol[i], (i == 4));
        end

        // Reset in the middle of a packet body.
        clear_out();
        set_cls(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send_pkt(4, 2, 8'h17, mk_user(8'h00, 8'h01));
        s_tvalid = 1'b1;
        s_tdata  = wd(8'h17, 2);
        #1;
        check("body_valid_before_reset", m_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 1'b0);
        check("midrst_m_tdata", m_tdata, 256'h0);
        check("midrst_s_tready", s_tready, 1'b0);
        check("midrst_word1", pkt_word1, 1'b0);
        s_tvalid = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        clear_out();
        send_pkt(2, 2, 8'h28, mk_user(8'h99, 8'h01));
        idle_cycles(4);
        check("post_rst_count", od.size(), 2);
        check("post_rst_hdr_user", ou[0], mk_user(8'h00, 8'h01));
        check("post_rst_w1_data", od[1], wd(8'h28, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_dispatch.md
Name: eth_dispatch

Overview:
- Sits directly downstream of the Ethernet header classifier inside the router output-port-lookup pcore.
- Accepts the input AXI-Stream and drives the classifier's first-word strobe.
- Holds the header word until the classifier result is valid, then either forwards the packet, redirects it to the CPU port paired with the ingress MAC port, or drops it.
- Its output feeds the IPv4 lookup stage.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 256, stream data width.
- C_S_AXIS_TUSER_WIDTH, 128, stream metadata width.
- SRC_PORT_POS, 16, LSB of the 8-bit source-port field in tuser.
- DST_PORT_POS, 24, LSB of the 8-bit destination-port field in tuser.
- CLS_TIMEOUT, 4, maximum cycles spent in WAIT_CLS before a forced drop; legal range 1..15.

Ports:
- axi_aclk  in  1  clock
- axi_resetn  in  1  asynchronous reset, active low
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  input data
- s_axis_tkeep  in  C_S_AXIS_TDATA_WIDTH/8  input byte enables
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  input metadata
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of packet
- m_axis_tdata  out  C_S_AXIS_TDATA_WIDTH  output data
- m_axis_tkeep  out  C_S_AXIS_TDATA_WIDTH/8  output byte enables
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  output metadata
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of packet
- o_pkt_word1  out  1  first-word strobe to classifier; equals s_axis_tvalid & s_axis_tready in IDLE
- i_is_for_us  in  1  classifier: destination MAC is ours or broadcast/multicast
- i_is_bmcast  in  1  classifier: broadcast/multicast
- i_is_arp  in  1  classifier: ethertype ARP
- i_is_ipv4  in  1  classifier: ethertype IPv4
- i_is_valid  in  1  classifier result valid

Behaviour:
- Clock and reset: single clock axi_aclk; axi_resetn is asynchronous and active low.
- Reset values: state=IDLE; s_axis_tready=0 while in reset; all m_axis_* outputs 0; o_pkt_word1=0; header register and timeout counter cleared.
- Reset mid-packet: remaining words of the interrupted packet are treated as new packets. Upstream is responsible for flushing them.
- IDLE:
  - s_axis_tready=1.
  - On handshake, latch the word (data, keep, user, last) into the header register, pulse o_pkt_word1 for that cycle, clear the timeout counter, and go to WAIT_CLS.
- WAIT_CLS:
  - s_axis_tready=0; the timeout counter increments each cycle.
  - Decisions are evaluated in priority order, and the first match applies:
    1. Source-port check: sport = header tuser[SRC_PORT_POS+7:SRC_PORT_POS].
       - If sport is not one-hot, go to DROP.
       - If sport & 8'hAA is nonzero (packet from a CPU port), go to PASS with tuser unchanged. No wait for the classifier.
    2. If i_is_valid=1:
       - i_is_for_us=0: go to DROP.
       - i_is_bmcast=1, i_is_arp=1, or i_is_ipv4=0: go to PASS with tuser destination field = (sport & 8'h55)<<1, i.e. the paired CPU port.
       - Otherwise (IPv4 unicast for us): go to PASS with the destination field forced to 8'h00. The lookup stage fills it.
    3. If the counter reaches CLS_TIMEOUT, go to DROP.
  - Earliest exit is the cycle after the first-word handshake, because the classifier output is registered. Header-to-output latency is therefore ≥2 cycles.
- PASS:
  - The header register is presented on m_axis with m_axis_tvalid=1 and s_axis_tready=0 until m_axis_tready.
  - After header handshake:
    - If the header tlast=1, return to IDLE.
    - Otherwise enter BODY.
- BODY:
  - Combinational pass-through: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready; data, keep, user and last are passed through.
  - On a tlast handshake, go to IDLE.
- DROP:
  - If the header tlast=1, return to IDLE next cycle.
  - Otherwise s_axis_tready=1, words are discarded, and m_axis_tvalid=0 until a tlast handshake, then IDLE.
- Classifier handling: i_is_valid is sampled only in WAIT_CLS and ignored in all other states.
- Backpressure: a stalled m_axis_tready holds m_axis_* stable. m_axis_tvalid never deasserts before its handshake.
- Throughput: one idle bubble between packets is accepted (IDLE→WAIT_CLS costs at least one input cycle).

Optional Feature:
- Macro ETH_DISPATCH_STATS_EN.
- When defined, adds outputs o_cnt_fwd, o_cnt_cpu, o_cnt_drop (each 32 bits) and input i_cnt_clr (1 bit).
- Each counter increments once per packet on the WAIT_CLS exit decision; the timeout drop counts as drop.
- Counters saturate at 32'hFFFFFFFF, clear on reset, and clear synchronously on i_cnt_clr. If clear and increment occur in the same cycle, clear wins.
- When not defined, none of these ports or counters exist.

Test Plan:
- 3-word IPv4 unicast from port 0 (tuser[23:16]=8'h01), classifier valid 1 cycle later with for_us=1, ipv4=1 → 3 output words; header tuser[31:24]=8'h00; o_pkt_word1 pulses exactly once.
- Broadcast ARP from port 2 (sport 8'h10), bmcast=1, arp=1 → packet passes with tuser[31:24]=8'h20, all words intact.
- Unicast to a foreign MAC from port 1 (sport 8'h04), for_us=0 → no m_axis_tvalid; all 4 input words consumed; next packet accepted.
- i_is_valid held 0 with CLS_TIMEOUT=4 → drop after 4 WAIT_CLS cycles. With stats enabled, o_cnt_drop=1.
- CPU-port source (sport 8'h02), single-word packet → passes unchanged in 2 cycles. Random m_axis_tready stalls on a 5-word forwarded packet → data order and tlast preserved, no duplicates.
- axi_resetn asserted mid-BODY → outputs zero immediately; after release the next packet is handled normally.
